// File: rtl/filter_window_stats_if.sv
`default_nettype none
// ============================================================================
// Module   : filter_window_stats_if
// Brief    : Sample-in / record-out bundle for the window statistics block.
// Revision : 1.0 - initial release
// ============================================================================
interface filter_window_stats_if;
    logic [15:0] in;
    logic        in_en;
    logic        flush;
    logic [15:0] out_avg;
    logic [15:0] out_max;
    logic [15:0] out_min;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        overflow;

    // Upstream filter and downstream consumer side
    modport master (
        output in, in_en, flush, out_ready,
        input  out_avg, out_max, out_min, out_valid, busy, overflow
    );

    // Statistics block side
    modport slave (
        input  in, in_en, flush, out_ready,
        output out_avg, out_max, out_min, out_valid, busy, overflow
    );
endinterface
`default_nettype wire

// File: rtl/filter_window_stats.sv
`default_nettype none
// ============================================================================
// Module   : filter_window_stats
// Brief    : Per-window average/max/min of a sample stream, queued in a FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module filter_window_stats #(
    parameter int WIN_LOG2   = 2,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    filter_window_stats_if.slave  bus
);

    localparam int WIN   = 1 << WIN_LOG2;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int SUM_W = 16 + WIN_LOG2;
    localparam int OCC_W = DEPTH_LOG2 + 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } state_t;

    state_t                  state_q,  state_d;
    logic [WIN_LOG2-1:0]     count_q,  count_d;
    logic [SUM_W-1:0]        sum_q,    sum_d;
    logic [15:0]             max_q,    max_d;
    logic [15:0]             min_q,    min_d;
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]        occ_q,    occ_d;
    logic                    overflow_q, overflow_d;
    logic [47:0]             mem_q [DEPTH];

    logic                    w_first;
    logic                    w_complete;
    logic [SUM_W-1:0]        w_sum_new;
    logic [15:0]             w_max_new;
    logic [15:0]             w_min_new;
    logic [47:0]             w_record;
    logic                    w_pop;
    logic                    w_push;
    logic                    w_full;
    logic                    w_drop;
    logic                    w_valid;
    logic [47:0]             w_head;

    // A flush discards history, so the same-edge sample opens a fresh window.
    always_comb begin
        w_first    = (state_q == ST_IDLE) || bus.flush;
        w_sum_new  = w_first ? SUM_W'(bus.in) : sum_q + SUM_W'(bus.in);
        w_max_new  = (w_first || (bus.in > max_q)) ? bus.in : max_q;
        w_min_new  = (w_first || (bus.in < min_q)) ? bus.in : min_q;
        w_complete = bus.in_en && !bus.flush && (count_q == WIN_LOG2'(WIN - 1));
        w_record   = {w_sum_new[WIN_LOG2 +: 16], w_max_new, w_min_new};
    end

    always_comb begin
        count_d = count_q;
        sum_d   = sum_q;
        max_d   = max_q;
        min_d   = min_q;
        if (bus.in_en) begin
            if (w_complete) begin
                count_d = '0;
                sum_d   = '0;
                max_d   = '0;
                min_d   = '0;
            end else begin
                count_d = w_first ? WIN_LOG2'(1) : count_q + WIN_LOG2'(1);
                sum_d   = w_sum_new;
                max_d   = w_max_new;
                min_d   = w_min_new;
            end
        end else if (bus.flush) begin
            count_d = '0;
            sum_d   = '0;
            max_d   = '0;
            min_d   = '0;
        end
        state_d = (count_d != '0) ? ST_ACC : ST_IDLE;
    end

    // Pop frees a slot on the same edge, so a full FIFO can still accept.
    always_comb begin
        w_valid    = (occ_q != '0);
        w_pop      = w_valid && bus.out_ready;
        w_full     = (occ_q == OCC_W'(DEPTH));
        w_push     = w_complete && (!w_full || w_pop);
        w_drop     = w_complete && w_full && !w_pop;
        wr_ptr_d   = w_push ? wr_ptr_q + DEPTH_LOG2'(1) : wr_ptr_q;
        rd_ptr_d   = w_pop  ? rd_ptr_q + DEPTH_LOG2'(1) : rd_ptr_q;
        occ_d      = occ_q;
        if (w_push && !w_pop) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (w_pop && !w_push) begin
            occ_d = occ_q - OCC_W'(1);
        end
        overflow_d = overflow_q || w_drop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            sum_q      <= '0;
            max_q      <= '0;
            min_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            sum_q      <= sum_d;
            max_q      <= max_d;
            min_q      <= min_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset; the outputs are gated by occupancy.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= w_record;
        end
    end

    assign w_head        = mem_q[rd_ptr_q];
    assign bus.out_valid = w_valid;
    assign bus.out_avg   = w_valid ? w_head[47:32] : 16'd0;
    assign bus.out_max   = w_valid ? w_head[31:16] : 16'd0;
    assign bus.out_min   = w_valid ? w_head[15:0]  : 16'd0;
    assign bus.busy      = (state_q == ST_ACC);
    assign bus.overflow  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_filter_window_stats.sv
`default_nettype none
// ============================================================================
// Module   : tb_filter_window_stats
// Brief    : Directed stimulus with a queued scoreboard for filter_window_stats.
// Revision : 1.0 - initial release
// ============================================================================
module tb_filter_window_stats;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          checks   = 0;
    int          failures = 0;
    logic [47:0] sb [$];

    filter_window_stats_if u_if ();

    filter_window_stats #(
        .WIN_LOG2   (2),
        .DEPTH_LOG2 (2)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [47:0] rec(input int a, input int mx, input int mn);
        logic [15:0] a16, mx16, mn16;
        a16  = 16'(a);
        mx16 = 16'(mx);
        mn16 = 16'(mn);
        return {a16, mx16, mn16};
    endfunction

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One clock of stimulus; returns 1 ns after the edge that consumed it.
    task automatic drive(input logic en, input logic [15:0] val, input logic fl);
        u_if.in_en = en;
        u_if.in    = val;
        u_if.flush = fl;
        @(posedge clk);
        #1;
        u_if.in_en = 1'b0;
        u_if.in    = 16'd0;
        u_if.flush = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 16'd0, 1'b0);
    endtask

    task automatic window4(input int a, input int b, input int c, input int d,
                           input logic [47:0] exp, input logic push_exp);
        drive(1'b1, 16'(a), 1'b0);
        drive(1'b1, 16'(b), 1'b0);
        drive(1'b1, 16'(c), 1'b0);
        if (push_exp) sb.push_back(exp);
        drive(1'b1, 16'(d), 1'b0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
    endtask

    // Monitor: head must match the oldest expected record; gated to zero when empty.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (u_if.out_valid === 1'b1) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_record actual=%0h required=none",
                                 {u_if.out_avg, u_if.out_max, u_if.out_min});
                    end else begin
                        check("record", {u_if.out_avg, u_if.out_max, u_if.out_min}, sb[0]);
                        if (u_if.out_ready === 1'b1) void'(sb.pop_front());
                    end
                end else begin
                    check("gated_data", {u_if.out_avg, u_if.out_max, u_if.out_min}, 48'd0);
                end
            end
        end
    end

    initial begin
        u_if.in        = 16'd0;
        u_if.in_en     = 1'b0;
        u_if.flush     = 1'b0;
        u_if.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_valid",    u_if.out_valid, 0);
        check("reset_busy",     u_if.busy,      0);
        check("reset_overflow", u_if.overflow,  0);
        check("reset_data", {u_if.out_avg, u_if.out_max, u_if.out_min}, 48'd0);

        // Basic window with one-cycle latency
        u_if.out_ready = 1'b1;
        drive(1'b1, 16'd10, 1'b0);
        check("t1_busy1", u_if.busy, 1);
        drive(1'b1, 16'd20, 1'b0);
        check("t1_busy2", u_if.busy, 1);
        drive(1'b1, 16'd30, 1'b0);
        check("t1_busy3", u_if.busy, 1);
        sb.push_back(rec(25, 40, 10));
        drive(1'b1, 16'd40, 1'b0);
        check("t1_busy_done", u_if.busy, 0);
        check("t1_valid", u_if.out_valid, 1);
        check("t1_avg", u_if.out_avg, 25);
        idle(1);
        check("t1_valid_one_cycle", u_if.out_valid, 0);

        // Full-scale samples with gaps; then truncating average
        for (int i = 0; i < 4; i++) begin
            if (i == 3) sb.push_back(rec(16'hFFFF, 16'hFFFF, 16'hFFFF));
            drive(1'b1, 16'hFFFF, 1'b0);
            idle(1);
        end
        window4(1, 1, 1, 2, rec(1, 2, 1), 1'b1);
        idle(2);

        // Fill FIFO, overflow on 5th window, then drain
        u_if.out_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            window4(k, k, k, k + 1, rec(k, k + 1, k), k <= 4);
            if (k == 4) begin
                check("t3_full_valid",   u_if.out_valid, 1);
                check("t3_no_overflow",  u_if.overflow,  0);
            end
        end
        check("t3_overflow", u_if.overflow, 1);
        u_if.out_ready = 1'b1;
        idle(3);
        check("t3_drain_valid", u_if.out_valid, 1);
        idle(1);
        check("t3_drain_empty",   u_if.out_valid, 0);
        check("t3_overflow_held", u_if.overflow,  1);
        pulse_reset();
        check("t3_overflow_cleared", u_if.overflow, 0);

        // Full FIFO with push and pop on the same edge
        u_if.out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) window4(k, k, k, k + 1, rec(k, k + 1, k), 1'b1);
        drive(1'b1, 16'd5, 1'b0);
        drive(1'b1, 16'd5, 1'b0);
        drive(1'b1, 16'd5, 1'b0);
        u_if.out_ready = 1'b1;
        sb.push_back(rec(5, 6, 5));
        drive(1'b1, 16'd6, 1'b0);
        check("t4_overflow", u_if.overflow, 0);
        idle(3);
        check("t4_drain_valid", u_if.out_valid, 1);
        idle(1);
        check("t4_drain_empty", u_if.out_valid, 0);
        check("t4_overflow_end", u_if.overflow, 0);

        // Flush with a same-edge sample restarts the window
        drive(1'b1, 16'd5, 1'b0);
        drive(1'b1, 16'd7, 1'b0);
        drive(1'b1, 16'd100, 1'b1);
        check("t5_busy_after_flush", u_if.busy, 1);
        drive(1'b1, 16'd100, 1'b0);
        drive(1'b1, 16'd100, 1'b0);
        sb.push_back(rec(100, 100, 100));
        drive(1'b1, 16'd100, 1'b0);
        check("t5_busy_done", u_if.busy, 0);
        idle(2);

        // Reset with queued records and a partial window
        u_if.out_ready = 1'b0;
        window4(1, 2, 3, 4, rec(2, 4, 1), 1'b1);
        window4(6, 6, 6, 6, rec(6, 6, 6), 1'b1);
        drive(1'b1, 16'd50, 1'b0);
        drive(1'b1, 16'd60, 1'b0);
        check("t6_busy_before", u_if.busy, 1);
        pulse_reset();
        check("t6_valid",    u_if.out_valid, 0);
        check("t6_busy",     u_if.busy,      0);
        check("t6_overflow", u_if.overflow,  0);
        check("t6_data", {u_if.out_avg, u_if.out_max, u_if.out_min}, 48'd0);
        u_if.out_ready = 1'b1;
        window4(8, 8, 8, 12, rec(9, 12, 8), 1'b1);
        idle(3);

        check("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
